// File: rtl/reset_sequencer_if.sv
// Board reset sequencer signal bundle: lock/boot/soft-reset inputs and domain reset requests.
// The master side is the sequencer; the slave side is the board top that drives and consumes it.
interface reset_sequencer_if;
  logic       i_locked;
  logic       i_soft_rst;
  logic       i_boot_sw;
  logic       o_reset_100MHz;
  logic       o_reset_50MHz;
  logic       o_reset_25MHz;
  logic       o_boot;
  logic       o_ready;
  logic [2:0] o_state;
  logic [7:0] o_seq_count;

  modport master (
    input  i_locked, i_soft_rst, i_boot_sw,
    output o_reset_100MHz, o_reset_50MHz, o_reset_25MHz,
    output o_boot, o_ready, o_state, o_seq_count
  );

  modport slave (
    output i_locked, i_soft_rst, i_boot_sw,
    input  o_reset_100MHz, o_reset_50MHz, o_reset_25MHz,
    input  o_boot, o_ready, o_state, o_seq_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: qualifies MMCM lock, holds all domains in reset, then
// releases 100/50/25 MHz reset requests in staggered order and latches the boot switch.
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES    = 63,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  reset_sequencer_if.master  bus
);

  localparam int unsigned SEQ_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [SEQ_W-1:0] SEQ_MAX      = '1;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_REL_100   = 3'd2,
    ST_REL_50    = 3'd3,
    ST_REL_25    = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  wire w_clock_25MHz = i_clock;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [SEQ_W-1:0] r_seq_count;
  logic             r_lock_meta;
  logic             r_lock_sync;
  logic             r_boot_meta;
  logic             r_boot_sync;
  logic             r_reset_100;
  logic             r_reset_50;
  logic             r_reset_25;
  logic             r_boot;
  logic             r_ready;

  // Sequencer FSM with synchronisers; every output is updated on the edge of its transition.
  always_ff @(posedge w_clock_25MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_WAIT_LOCK;
      r_count     <= '0;
      r_seq_count <= '0;
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_boot_meta <= 1'b0;
      r_boot_sync <= 1'b0;
      r_reset_100 <= 1'b1;
      r_reset_50  <= 1'b1;
      r_reset_25  <= 1'b1;
      r_boot      <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_lock_meta <= bus.i_locked;
      r_lock_sync <= r_lock_meta;
      r_boot_meta <= bus.i_boot_sw;
      r_boot_sync <= r_boot_meta;

      // Lock loss overrides everything, including a pending soft reset.
      if ((r_state != ST_WAIT_LOCK) && !r_lock_sync) begin
        r_state     <= ST_WAIT_LOCK;
        r_count     <= '0;
        r_reset_100 <= 1'b1;
        r_reset_50  <= 1'b1;
        r_reset_25  <= 1'b1;
        r_ready     <= 1'b0;
      end else begin
        case (r_state)
          ST_WAIT_LOCK: begin
            if (r_lock_sync) begin
              r_state <= ST_HOLD;
              r_count <= HOLD_LOAD;
            end
          end
          ST_HOLD: begin
            if (r_count == '0) begin
              r_state     <= ST_REL_100;
              r_count     <= STAGGER_LOAD;
              r_boot      <= r_boot_sync;
              r_reset_100 <= 1'b0;
            end else begin
              r_count <= r_count - CNT_W'(1);
            end
          end
          ST_REL_100: begin
            if (r_count == '0) begin
              r_state    <= ST_REL_50;
              r_count    <= STAGGER_LOAD;
              r_reset_50 <= 1'b0;
            end else begin
              r_count <= r_count - CNT_W'(1);
            end
          end
          ST_REL_50: begin
            if (r_count == '0) begin
              r_state    <= ST_REL_25;
              r_count    <= STAGGER_LOAD;
              r_reset_25 <= 1'b0;
            end else begin
              r_count <= r_count - CNT_W'(1);
            end
          end
          ST_REL_25: begin
            if (r_count == '0) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
              if (r_seq_count != SEQ_MAX) begin
                r_seq_count <= r_seq_count + SEQ_W'(1);
              end
            end else begin
              r_count <= r_count - CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (bus.i_soft_rst) begin
              r_state     <= ST_HOLD;
              r_count     <= HOLD_LOAD;
              r_reset_100 <= 1'b1;
              r_reset_50  <= 1'b1;
              r_reset_25  <= 1'b1;
              r_ready     <= 1'b0;
            end
          end
          default: begin
            r_state     <= ST_WAIT_LOCK;
            r_count     <= '0;
            r_reset_100 <= 1'b1;
            r_reset_50  <= 1'b1;
            r_reset_25  <= 1'b1;
            r_ready     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_reset_100MHz = r_reset_100;
  assign bus.o_reset_50MHz  = r_reset_50;
  assign bus.o_reset_25MHz  = r_reset_25;
  assign bus.o_boot         = r_boot;
  assign bus.o_ready        = r_ready;
  assign bus.o_state        = r_state;
  assign bus.o_seq_count    = r_seq_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues the expected output snapshot and edge
// of every state change; a negedge monitor pops and compares whenever the outputs change.
module tb_reset_sequencer;

  typedef struct {
    int         edge_no;   // posedge index at which the change must appear, -1 = any
    logic [2:0] st;
    logic [2:0] rst;       // {100, 50, 25}
    logic       rdy;
    logic       boot;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q[$];
  logic       m_boot;
  logic [7:0] m_cnt;

  reset_sequencer_if u_if();

  reset_sequencer #(
    .HOLD_CYCLES    (63),
    .STAGGER_CYCLES (4),
    .CNT_W          (8)
  ) u_dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: run did not finish, got edge %0d, required finish before 60000", edge_cnt);
    $fatal(1);
  end

  task automatic push_e(input int e, input logic [2:0] st, input logic [2:0] r, input logic rdy);
    exp_t x;
    x.edge_no = e;
    x.st      = st;
    x.rst     = r;
    x.rdy     = rdy;
    x.boot    = m_boot;
    x.cnt     = m_cnt;
    q.push_back(x);
  endtask

  // Full HOLD -> RUN sequence starting with HOLD entry at edge h; b is the boot value latched.
  task automatic push_seq(input int h, input logic b);
    push_e(h, 3'd1, 3'b111, 1'b0);
    m_boot = b;
    push_e(h + 64, 3'd2, 3'b011, 1'b0);
    push_e(h + 68, 3'd3, 3'b001, 1'b0);
    push_e(h + 72, 3'd4, 3'b000, 1'b0);
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    push_e(h + 76, 3'd5, 3'b000, 1'b1);
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Monitor: any change of the observable outputs must match the next queued expectation.
  initial begin
    logic [15:0] obs;
    logic [15:0] prev;
    logic [15:0] want;
    bit          have_prev;
    exp_t        e;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      obs = {u_if.o_state, u_if.o_reset_100MHz, u_if.o_reset_50MHz, u_if.o_reset_25MHz,
             u_if.o_ready, u_if.o_boot, u_if.o_seq_count};
      if (!have_prev || obs !== prev) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change at edge %0d: got state=%0d rst=%b rdy=%b boot=%b cnt=%0d, required no change",
                   edge_cnt, obs[15:13], obs[12:10], obs[9], obs[8], obs[7:0]);
        end else begin
          e    = q.pop_front();
          want = {e.st, e.rst, e.rdy, e.boot, e.cnt};
          if (obs === want && (e.edge_no < 0 || e.edge_no == edge_cnt)) begin
            n_pass++;
          end else begin
            $display("FAIL enter_state_%0d: got edge=%0d state=%0d rst=%b rdy=%b boot=%b cnt=%0d, required edge=%0d state=%0d rst=%b rdy=%b boot=%b cnt=%0d",
                     e.st, edge_cnt, obs[15:13], obs[12:10], obs[9], obs[8], obs[7:0],
                     e.edge_no, e.st, e.rst, e.rdy, e.boot, e.cnt);
          end
        end
        prev      = obs;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    int k;
    rst_n           = 1'b0;
    u_if.i_locked   = 1'b1;
    u_if.i_soft_rst = 1'b0;
    u_if.i_boot_sw  = 1'b0;
    m_boot          = 1'b0;
    m_cnt           = 8'd0;
    push_e(-1, 3'd0, 3'b111, 1'b0);
    repeat (3) @(negedge clk);

    // Power-up sequence with lock already present; boot switch high during HOLD.
    rst_n          = 1'b1;
    u_if.i_boot_sw = 1'b1;
    k = edge_cnt;
    push_seq(k + 3, 1'b1);
    wait_edge(k + 79);

    // Boot switch toggled in RUN must not disturb o_boot.
    u_if.i_boot_sw = 1'b0;
    repeat (6) @(negedge clk);
    u_if.i_boot_sw = 1'b1;
    repeat (3) @(negedge clk);

    // Soft reset, then a one-cycle lock drop while in REL_50.
    k = edge_cnt;
    u_if.i_soft_rst = 1'b1;
    push_e(k + 1, 3'd1, 3'b111, 1'b0);
    m_boot = 1'b1;
    push_e(k + 65, 3'd2, 3'b011, 1'b0);
    push_e(k + 69, 3'd3, 3'b001, 1'b0);
    @(negedge clk);
    u_if.i_soft_rst = 1'b0;
    wait_edge(k + 69);
    u_if.i_locked = 1'b0;
    @(negedge clk);
    u_if.i_locked = 1'b1;
    push_e(k + 72, 3'd0, 3'b111, 1'b0);
    push_seq(k + 73, 1'b1);
    wait_edge(k + 149);

    // Soft-reset pulse with the boot switch now low.
    u_if.i_boot_sw = 1'b0;
    repeat (3) @(negedge clk);
    k = edge_cnt;
    u_if.i_soft_rst = 1'b1;
    push_seq(k + 1, 1'b0);
    @(negedge clk);
    u_if.i_soft_rst = 1'b0;
    wait_edge(k + 77);

    // Soft reset and lock loss seen on the same edge in RUN.
    k = edge_cnt;
    u_if.i_locked = 1'b0;
    @(negedge clk);
    u_if.i_locked = 1'b1;
    @(negedge clk);
    u_if.i_soft_rst = 1'b1;
    push_e(k + 3, 3'd0, 3'b111, 1'b0);
    @(negedge clk);
    u_if.i_soft_rst = 1'b0;
    push_seq(k + 4, 1'b0);
    wait_edge(k + 80);

    // Short mid-cycle board reset pulse while HOLD counter is 20.
    u_if.i_boot_sw = 1'b1;
    repeat (3) @(negedge clk);
    k = edge_cnt;
    u_if.i_soft_rst = 1'b1;
    push_e(k + 1, 3'd1, 3'b111, 1'b0);
    @(negedge clk);
    u_if.i_soft_rst = 1'b0;
    wait_edge(k + 44);
    m_boot = 1'b0;
    m_cnt  = 8'd0;
    push_e(k + 45, 3'd0, 3'b111, 1'b0);
    #5 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    push_seq(k + 47, 1'b1);
    wait_edge(k + 123);

    // Soft reset held high: back-to-back sequences until the counter saturates.
    k = edge_cnt;
    u_if.i_soft_rst = 1'b1;
    for (int i = 0; i < 300; i++) push_seq(k + 1 + 77 * i, 1'b1);
    wait_edge(k + 77 * 300);
    u_if.i_soft_rst = 1'b0;
    repeat (10) @(negedge clk);

    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL missing_changes: got %0d expected changes never seen, required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
